// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared constants and types for the multiply/divide unit.
//   - md_op codes (MULT/MULTU/DIV/DIVU)
//   - moveto/movefrom codes (NONE/HI/LO)
//   - default latency constants
//   - FSM state type and a small op-class helper
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] MV_HI   = 2'b01;
  localparam logic [1:0] MV_LO   = 2'b10;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Divides are the two codes with the upper bit set.
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: EX-stage bus between the pipeline and the multiply/divide unit.
//   master: pipeline side (drives start/md_op/A/B/moveto/movefrom/cancel)
//   slave : md_unit side (drives busy/md_stall/HI/LO/md_out and debug state)
//
// Handshake: start is a one-cycle request, accepted at a rising edge only when
// busy=0 and cancel=0. There is no ready back-pressure on the request itself;
// instead md_stall (= busy | start & ~cancel) tells the hazard unit to hold
// ID, so the pipeline never presents start while busy=1.
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  moveto;
  logic [1:0]  movefrom;
  logic        cancel;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;
  md_state_e   dbg_state;
  logic [1:0]  dbg_op;

  modport master (
    output start, md_op, A, B, moveto, movefrom, cancel,
    input  busy, md_stall, HI, LO, md_out, dbg_state, dbg_op
  );

  modport slave (
    input  start, md_op, A, B, moveto, movefrom, cancel,
    output busy, md_stall, HI, LO, md_out, dbg_state, dbg_op
  );
endinterface

// File: rtl/md_arith.sv
// md_arith: purely combinational result generator for the four md ops.
//   op_i  : md_op code
//   a_i   : rs operand (dividend / multiplicand)
//   b_i   : rt operand (divisor / multiplier)
//   hi_o  : HI result (product high word / remainder)
//   lo_o  : LO result (product low word / quotient)
//   dz_o  : divide op with b_i == 0
module md_arith
  import md_unit_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dz_o
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] prod;

  always_comb begin
    // Signed divide works on magnitudes; signs are restored afterwards.
    a_neg = (op_i == MD_DIV) && a_i[31];
    b_neg = (op_i == MD_DIV) && b_i[31];
    a_mag = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag = b_neg ? (~b_i + 32'd1) : b_i;
    // Substitute 1 for a zero divisor so the datapath never divides by zero;
    // the result is discarded via dz_o anyway.
    div_b = (b_i == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / div_b;
    r_mag = a_mag % div_b;
    dz_o  = is_div(op_i) && (b_i == 32'd0);

    prod = 64'd0;
    hi_o = 32'd0;
    lo_o = 32'd0;
    case (md_op_e'(op_i))
      MD_MULT: begin
        // Low 64 bits of the product of sign-extended operands equal the
        // signed 64-bit product.
        prod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      MD_MULTU: begin
        prod = {32'd0, a_i} * {32'd0, b_i};
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      default: begin
        // 0x80000000 / -1 gives magnitude 0x80000000, whose negation wraps
        // back to 0x80000000 with remainder 0.
        lo_o = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        hi_o = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the architectural HI/LO.
//   clk    : clock, rising-edge
//   reset  : synchronous active-high reset
//   bus    : md_unit_if.slave
//            in : start, md_op, A, B, moveto, movefrom, cancel
//            out: busy, md_stall, HI, LO, md_out, dbg_state, dbg_op
// The result is computed at accept time into phi/plo and committed to HI/LO
// after a fixed latency of MULT_CYC or DIV_CYC cycles.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input logic   clk,
  input logic   reset,
  md_unit_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        phi_q, phi_d;
  logic [31:0]        plo_q, plo_d;
  logic               dz_q, dz_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [31:0]        ar_hi;
  logic [31:0]        ar_lo;
  logic               ar_dz;
  logic               go;
  logic               done;

  md_arith u_arith (
    .op_i (bus.md_op),
    .a_i  (bus.A),
    .b_i  (bus.B),
    .hi_o (ar_hi),
    .lo_o (ar_lo),
    .dz_o (ar_dz)
  );

  // Start is only taken while idle; a start while busy is a hazard-unit bug
  // and is dropped.
  assign go   = bus.start && !bus.cancel && (state_q == ST_IDLE);
  assign done = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: FSM and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_RUN;
          cnt_d   = is_div(bus.md_op) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end
      end
      ST_RUN: begin
        if (done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-state: pending result and HI/LO.
  always_comb begin
    op_d  = op_q;
    phi_d = phi_q;
    plo_d = plo_q;
    dz_d  = dz_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (go) begin
      // start wins over a same-cycle moveto.
      op_d  = bus.md_op;
      phi_d = ar_hi;
      plo_d = ar_lo;
      dz_d  = ar_dz;
    end else if ((state_q == ST_IDLE) && !bus.cancel) begin
      if (bus.moveto == MV_HI) hi_d = bus.A;
      if (bus.moveto == MV_LO) lo_d = bus.A;
    end
    if (done && !dz_q) begin
      hi_d = phi_q;
      lo_d = plo_q;
    end
  end

  // Outputs.
  always_comb begin
    bus.busy      = (state_q == ST_RUN);
    bus.md_stall  = (state_q == ST_RUN) || (bus.start && !bus.cancel);
    bus.HI        = hi_q;
    bus.LO        = lo_q;
    bus.dbg_state = state_q;
    bus.dbg_op    = op_q;
    case (bus.movefrom)
      MV_HI:   bus.md_out = hi_q;
      MV_LO:   bus.md_out = lo_q;
      default: bus.md_out = 32'd0;
    endcase
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage, fed directly by the ID/EX control register (op select, `moveto`, `movefrom`) and by the forwarded EX operands. It owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations and serves MTHI/MTLO and MFHI/MFLO. It exports a busy/stall indication that the hazard unit turns into ID stalls and ID/EX clears.

## Interface
Parameters:
- `MULT_CYC`, default 5: cycles from accepted multiply start until HI/LO hold the result.
- `DIV_CYC`, default 10: cycles from accepted divide start until HI/LO hold the result.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous active-high reset.
- `start`, input, 1: launch the operation given by `md_op` this cycle.
- `md_op`, input, 2: operation select, using shared-header constants MULT=0, MULTU=1, DIV=2, DIVU=3.
- `A`, input, 32: forwarded rs operand, the dividend or multiplicand.
- `B`, input, 32: forwarded rt operand, the divisor or multiplier.
- `moveto`, input, 2: 00 none, 01 write HI, 10 write LO, 11 reserved (no effect).
- `movefrom`, input, 2: 00 none, 01 read HI, 10 read LO.
- `cancel`, input, 1: exception/eret flush of the EX instruction; suppresses `start` and `moveto` in the same cycle.
- `busy`, output, 1: an operation is in flight.
- `md_stall`, output, 1: `busy | (start & ~cancel)`; consumed by the hazard unit.
- `HI`, output, 32: architectural HI register.
- `LO`, output, 32: architectural LO register.
- `md_out`, output, 32: `HI` when `movefrom`=01, `LO` when 10, 0 otherwise; combinational.

## Operation
- Two-state FSM: IDLE and RUN. A down-counter `cnt` holds the remaining cycles.
- IDLE to RUN on `start & ~cancel`:
  - Latch `md_op`.
  - Load `cnt` with `MULT_CYC` for multiplies or `DIV_CYC` for divides.
  - Compute the result from A/B into pending registers `phi`/`plo`.
- Result rules:
  - MULT: {phi,plo} = signed 64-bit product.
  - MULTU: {phi,plo} = unsigned 64-bit product.
  - DIV: plo = quotient truncated toward zero; phi = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B=0): HI and LO are left unchanged when the operation completes; a flag records this.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- RUN: `cnt` decrements each cycle. When `cnt`==1, HI/LO are written from `phi`/`plo` (unless divide-by-zero) and the FSM returns to IDLE.
- `start` while busy: ignored. The hazard unit prevents it; the bench flags it as a protocol error.
- `moveto` with `~cancel` and `~busy`: writes A into HI or LO at the next edge.
- `moveto` while busy: ignored.
- If `moveto` and `start` arrive in the same cycle, `start` wins and `moveto` is ignored.
- `cancel` never aborts an operation already in RUN; the instruction that launched it has already committed.
- `movefrom` reads are not blocked internally. The hazard unit stalls MFHI/MFLO while `md_stall`=1.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, `busy`=0, `HI`=0, `LO`=0, `phi`=0, `plo`=0.
- Reset in RUN: the operation is abandoned, everything returns to reset values, and HI/LO are cleared.
- Start accepted at edge t0: `busy`=1 from t0 through edge t0+N-1. The new HI/LO are visible, with `busy`=0, after edge t0+N, where N = `MULT_CYC` or `DIV_CYC`.
- Back-to-back operations: a new `start` is accepted in the first cycle with `busy`=0.
- `md_stall` is asserted combinationally in the start cycle itself. A dependent instruction in ID therefore stalls with no one-cycle hole.
- MTHI/MTLO latency is 1 cycle; `md_out` reflects the new value in the following cycle.
- A parameter value below 1 is illegal.

## Structure
- Shared header (the same `include` as the pipeline registers) holds:
  - the `md_op` codes;
  - the `moveto`/`movefrom` codes (NONE/HI/LO);
  - the default latency constants.
- Sub-module `md_arith`: purely combinational; computes the {hi,lo} result for the four ops, including the sign fix-ups and the divide-by-zero flag.
- `md_unit` contains the FSM, the counter, the pending registers and HI/LO.

## Test plan
- Signed multiply: MULT with A=0xFFFFFFFE (-2), B=3 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; `md_stall` is high in the start cycle.
- Unsigned multiply: MULTU with A=0xFFFFFFFF, B=2 → HI=1, LO=0xFFFFFFFE after 5 cycles.
- Signed divide: DIV with A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide edge cases:
  - DIVU with A=7, B=0 → HI/LO keep their prior values (e.g. 0x11/0x22).
  - DIV with A=0x80000000, B=-1 → LO=0x80000000, HI=0.
- Move and cancel:
  - MTHI with A=0x1234 while idle → MFHI next cycle returns 0x1234.
  - MTLO while busy → ignored.
  - `start` together with `cancel` → `busy` stays 0 and HI/LO are unchanged.
- Reset in RUN: reset asserted 3 cycles into a DIV → next cycle `busy`=0, HI=LO=0; a subsequent MULT 5×5 gives LO=25 after 5 cycles.
